// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-position rotate sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/shift_seq_if.sv
// Bundle of the controller request/response signals and the shift-unit drive/return lines.
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             cf;

  // Sequencer side of the combinational shift unit.
  logic [WIDTH-1:0] a;
  logic             fbus;
  logic             flbus;
  logic             frbus;
  logic [WIDTH-1:0] w;
  logic             cf_in;

  modport master (
    output start, dir, count, din,
    input  busy, done, q, cf
  );

  modport slave (
    input  start, dir, count, din, w, cf_in,
    output busy, done, q, cf, a, fbus, flbus, frbus
  );

endinterface

// File: rtl/shift.sv
// Combinational one-bit rotate unit: pass-through, rotate left or rotate right by one.
module shift #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             fbus,
  input  logic             flbus,
  input  logic             frbus,
  output logic [WIDTH-1:0] w,
  output logic             cf
);

  // With no select active the result is undefined to the sequencer; drive zero.
  always_comb begin
    w  = '0;
    cf = 1'b0;
    if (fbus) begin
      w = a;
    end else if (flbus) begin
      w  = {a[WIDTH-2:0], a[WIDTH-1]};
      cf = a[WIDTH-1];
    end else if (frbus) begin
      w  = {a[0], a[WIDTH-1:1]};
      cf = a[0];
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Rotate sequencer: walks an operand through the one-bit shift unit count times and
// returns the result and last carry with a done pulse.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic        clk,
  input logic        rst,
  shift_seq_if.slave bus
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg;
  logic             dir_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic             cf_reg;
  logic             enter_done;

  assign enter_done = (state_next == DONE) && (state_reg != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      dir_reg   <= DIR_L;
      rem_reg   <= '0;
      q_reg     <= '0;
      cf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            work_reg <= bus.din;
            dir_reg  <= bus.dir;
            rem_reg  <= bus.count;
            cf_reg   <= 1'b0;
          end
        end
        LOAD: begin
          work_reg <= bus.w;
        end
        SHIFT: begin
          work_reg <= bus.w;
          cf_reg   <= bus.cf_in;
          rem_reg  <= rem_reg - CNT_W'(1);
        end
        default: ;
      endcase
      // The result is whatever the shift unit returns on the edge that enters DONE.
      if (enter_done) begin
        q_reg <= bus.w;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    bus.fbus   = 1'b0;
    bus.flbus  = 1'b0;
    bus.frbus  = 1'b0;
    bus.done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        bus.fbus   = 1'b1;
        state_next = (rem_reg == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        bus.flbus = (dir_reg == DIR_L);
        bus.frbus = (dir_reg == DIR_R);
        if (rem_reg == CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.a    = work_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.q    = q_reg;
  assign bus.cf   = cf_reg;

endmodule
